// File: rtl/commit_ctrl.sv
// In-order commit sequencer at the ROB head: retires one entry per cycle, writes back, runs store handshake, raises flush.
// Latency: pop/rf_*/mispredict are combinational from state+head (0-cycle commit); st_req rises the edge after a STORE head.
// Backpressure: rdy=0 freezes state and counters and zeroes strobes; a store waits in WAIT_ST until st_ack.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global ready; low freezes the block
//   head_*              ROB head entry (valid, tag, type, rd, value, mispredict flag, correct target)
//   st_ack              LSB has performed the committed store
//   pop                 dequeue ROB head
//   rf_we/rd/q/v        RegFile writeback port
//   st_req/st_id        store-commit request to the LSB (registered)
//   mispredict          one-cycle flush pulse; redirect_pc is the fetch restart PC while it is high
//   commit_cnt          retired-instruction counter, wraps modulo 2^32
module commit_ctrl #(
    parameter int ROB_ID_W     = 4,
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                head_valid,
    input  logic [ROB_ID_W-1:0] head_id,
    input  logic [1:0]          head_type,
    input  logic [4:0]          head_rd,
    input  logic [XLEN-1:0]     head_value,
    input  logic                head_mispred,
    input  logic [XLEN-1:0]     head_target,
    input  logic                st_ack,
    output logic                pop,
    output logic                rf_we,
    output logic [4:0]          rf_rd,
    output logic [ROB_ID_W-1:0] rf_q,
    output logic [XLEN-1:0]     rf_v,
    output logic                st_req,
    output logic [ROB_ID_W-1:0] st_id,
    output logic                mispredict,
    output logic [XLEN-1:0]     redirect_pc,
    output logic [31:0]         commit_cnt
);

    localparam logic [1:0] T_REG    = 2'b00;
    localparam logic [1:0] T_STORE  = 2'b01;
    localparam logic [1:0] T_BRANCH = 2'b10;
    localparam logic [1:0] T_JUMP   = 2'b11;

    localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        RUN,
        WAIT_ST,
        FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         flush_cnt_q, flush_cnt_d;
    logic                  st_req_d;
    logic [ROB_ID_W-1:0]   st_id_d;
    logic [31:0]           commit_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            st_req      <= 1'b0;
            st_id       <= '0;
            commit_cnt  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            st_req      <= st_req_d;
            st_id       <= st_id_d;
            commit_cnt  <= commit_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        st_req_d     = st_req;
        st_id_d      = st_id;
        commit_cnt_d = commit_cnt;
        pop          = 1'b0;
        rf_we        = 1'b0;
        rf_rd        = head_rd;
        rf_q         = head_id;
        rf_v         = head_value;
        mispredict   = 1'b0;
        redirect_pc  = '0;

        // Holding everything at its current value while !rdy is what freezes the block.
        if (!rst && rdy) begin
            case (state_q)
                RUN: begin
                    if (head_valid) begin
                        case (head_type)
                            T_REG: begin
                                pop   = 1'b1;
                                rf_we = (head_rd != 5'd0);
                            end
                            T_STORE: begin
                                // The store is not popped until the LSB acknowledges it.
                                st_req_d = 1'b1;
                                st_id_d  = head_id;
                                state_d  = WAIT_ST;
                            end
                            T_BRANCH, T_JUMP: begin
                                pop   = 1'b1;
                                rf_we = (head_type == T_JUMP) && (head_rd != 5'd0);
                                if (head_mispred) begin
                                    mispredict  = 1'b1;
                                    redirect_pc = head_target;
                                    flush_cnt_d = FLUSH_LOAD;
                                    state_d     = FLUSH;
                                end
                            end
                        endcase
                    end
                end
                WAIT_ST: begin
                    // head_valid is deliberately not consulted: the store is already committed.
                    if (st_ack) begin
                        pop      = 1'b1;
                        st_req_d = 1'b0;
                        state_d  = RUN;
                    end
                end
                FLUSH: begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                    if (flush_cnt_q <= FW'(1)) begin
                        flush_cnt_d = '0;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (pop) begin
            commit_cnt_d = commit_cnt + 32'd1;
        end
    end

endmodule
